// File: rtl/io_feeder_pkg.sv
// Shared types and constants for the batch feeder: controller states and
// the cmd encoding seen by the accelerator chip.
package io_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD         = 3'd1,
    GAP          = 3'd2,
    PROCESS      = 3'd3,
    COLLECT_WAIT = 3'd4,
    COLLECT      = 3'd5
  } state_t;

  localparam logic CMD_LOAD    = 1'b1;
  localparam logic CMD_PROCESS = 1'b0;

endpackage

// File: rtl/io_batch_feeder_sync_fifo.sv
// Single-clock FIFO with registered storage and pointers; dout is the current
// head entry. A push while full only succeeds if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/io_batch_feeder.sv
// Host-to-chip batch feeder: queues load words, hands them to the chip over
// intrpt/cmd/done, then issues process and collects RES_WORDS results.
module io_batch_feeder
  import io_feeder_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int RES_DEPTH = 8,
  parameter int RES_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              intrpt,
  output logic              cmd,
  output logic [DATA_W-1:0] dataBus,
  input  logic              done,
  input  logic [DATA_W-1:0] chip_result,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              busy,
  output logic              res_ovf
);

  localparam int CW = $clog2(RES_WORDS + 1);
  localparam logic [CW-1:0] RES_CNT_MAX = CW'(RES_WORDS);
  localparam logic [CW-1:0] RES_CNT_ONE = CW'(1);

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic            intrpt_q, intrpt_d;
  logic            cmd_q, cmd_d;
  logic            res_ovf_q, res_ovf_d;

  logic                    ld_push, ld_pop, ld_full, ld_empty;
  logic [DATA_W:0]         ld_dout;
  logic [$clog2(DEPTH):0]  ld_count;
  logic                    res_push, res_pop, res_full, res_empty;
  logic [$clog2(RES_DEPTH):0] res_count;
  logic                    unused_counts;

  // Load FIFO entries are {last, data}.
  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_load_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ld_push),
    .pop   (ld_pop),
    .din   ({wr_last, wr_data}),
    .dout  (ld_dout),
    .full  (ld_full),
    .empty (ld_empty),
    .count (ld_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RES_DEPTH)) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (res_push),
    .pop   (res_pop),
    .din   (chip_result),
    .dout  (rd_data),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign unused_counts = ^{ld_count, res_count};

  assign wr_ready = !ld_full;
  assign ld_push  = wr_valid && !ld_full;
  assign rd_valid = !res_empty;
  assign res_pop  = !res_empty && rd_ready;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    intrpt_d  = 1'b0;
    ld_pop    = 1'b0;
    res_push  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ld_empty && !done) state_d = LOAD;
      end
      // intrpt is registered, so it rises one cycle after entering LOAD/PROCESS
      // and falls on the same edge that takes the acknowledge.
      LOAD: begin
        if (done) begin
          ld_pop  = 1'b1;
          last_d  = ld_dout[DATA_W];
          state_d = GAP;
        end else begin
          intrpt_d = 1'b1;
        end
      end
      GAP: begin
        if (!done) begin
          if (last_q)         state_d = PROCESS;
          else if (!ld_empty) state_d = LOAD;
        end
      end
      PROCESS: begin
        if (done) begin
          last_d    = 1'b0;
          res_cnt_d = '0;
          state_d   = COLLECT_WAIT;
        end else begin
          intrpt_d = 1'b1;
        end
      end
      COLLECT_WAIT: begin
        if (!done) state_d = COLLECT;
      end
      COLLECT: begin
        if (done) begin
          res_push  = 1'b1;
          res_cnt_d = res_cnt_q + RES_CNT_ONE;
          if (res_full && !res_pop) res_ovf_d = 1'b1;
          if (res_cnt_d == RES_CNT_MAX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_d = ((state_d == PROCESS) || (state_d == COLLECT_WAIT) || (state_d == COLLECT))
            ? CMD_PROCESS : CMD_LOAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      res_cnt_q <= '0;
      intrpt_q  <= 1'b0;
      cmd_q     <= CMD_LOAD;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      res_cnt_q <= res_cnt_d;
      intrpt_q  <= intrpt_d;
      cmd_q     <= cmd_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign intrpt  = intrpt_q;
  assign cmd     = cmd_q;
  assign busy    = (state_q != IDLE);
  assign res_ovf = res_ovf_q;
  assign dataBus = (state_q == LOAD) ? ld_dout[DATA_W-1:0] : '0;

endmodule

// File: doc/io_batch_feeder.md
Name: io_batch_feeder

Overview:
- Synthesizable, parametrised successor of the file-driven I/O feeder.
- Buffers a host-supplied batch of load words in an internal FIFO and presents them to the accelerator chip using the intrpt/cmd/done protocol.
- After the batch's last word, issues the process command and collects a fixed number of result words into a second FIFO for the host.
- Sits between the host/testbench stimulus port and the accelerator chip's I/O module.

Parameters:
- DATA_W, 32, width of dataBus, host write data and result data.
- DEPTH, 16, load FIFO entries; power of two, minimum 2.
- RES_DEPTH, 8, result FIFO entries; power of two, minimum 2.
- RES_WORDS, 4, number of result words collected after each process command; minimum 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_valid  in  1  host offers a load word.
- wr_data  in  DATA_W  load word.
- wr_last  in  1  marks the final word of a batch.
- wr_ready  out  1  load FIFO not full.
- intrpt  out  1  notifies the chip of a pending command.
- cmd  out  1  1 = load, 0 = process.
- dataBus  out  DATA_W  load word presented to the chip.
- done  in  1  chip acknowledge / result strobe.
- chip_result  in  DATA_W  result word; valid when done is high in COLLECT.
- rd_valid  out  1  result FIFO not empty.
- rd_data  out  DATA_W  result FIFO head.
- rd_ready  in  1  host pops a result when high with rd_valid.
- busy  out  1  state is not IDLE.
- res_ovf  out  1  sticky; a result word was dropped.

Behaviour:
- Reset values:
  - intrpt = 0, cmd = 1, dataBus = 0, wr_ready = 1, rd_valid = 0, busy = 0, res_ovf = 0.
  - Both FIFOs empty; state IDLE; result counter 0.
- Reset asserted mid-operation aborts any transfer and flushes both FIFOs immediately. There is no partial recovery.
- Load FIFO:
  - Each entry holds {last, data}.
  - A write is accepted when wr_valid && wr_ready.
  - wr_ready = !full, combinational on the registered count.
  - A write while full is ignored.
  - A write and a pop in the same cycle are both performed; the count is unchanged.
- dataBus always shows the load FIFO head when in LOAD, and 0 otherwise.
- State IDLE:
  - intrpt = 0.
  - If the FIFO is non-empty and done = 0, go to LOAD next cycle.
  - A word written into an empty FIFO at edge t therefore drives intrpt = 1 from edge t+2.
- State LOAD:
  - intrpt = 1, cmd = 1.
  - On done = 1: pop the head, latch its last bit into last_q, drop intrpt, go to GAP.
- State GAP:
  - intrpt = 0.
  - Wait for done = 0. Once done = 0:
    - last_q = 1: go to PROCESS.
    - else FIFO non-empty: go to LOAD.
    - else stay in GAP (mid-batch starvation; intrpt stays 0).
- State PROCESS:
  - intrpt = 1, cmd = 0.
  - On done = 1: intrpt <= 0, clear last_q, clear the result counter, go to COLLECT_WAIT.
- State COLLECT_WAIT:
  - Wait for done = 0, then go to COLLECT.
  - This keeps the process acknowledge from being counted as a result.
- State COLLECT:
  - intrpt = 0, cmd = 0.
  - Each cycle with done = 1 captures chip_result into the result FIFO and increments the counter. A multi-cycle done high captures one word per cycle.
  - If the result FIFO is full and not being popped that cycle, the word is dropped, res_ovf <= 1, and the counter still increments.
  - When the counter reaches RES_WORDS, return to IDLE; cmd <= 1 on the next cycle.
- done is ignored in IDLE and in GAP except for the low-level wait.
- Load words written during PROCESS/COLLECT are queued and served after the return to IDLE.
- Result FIFO:
  - rd_data is the registered head.
  - A pop occurs when rd_valid && rd_ready.
  - A simultaneous push and pop is allowed when full.
- res_ovf is cleared only by reset.
- Counter widths: load count $clog2(DEPTH)+1; result counter $clog2(RES_WORDS+1). No wrap is possible.

Decomposition:
- Package io_feeder_pkg:
  - State enum (IDLE, LOAD, GAP, PROCESS, COLLECT_WAIT, COLLECT).
  - Constants CMD_LOAD = 1'b1, CMD_PROCESS = 1'b0.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports push, pop, din, dout, full, empty, count; asynchronous reset.
  - Instantiated twice: load FIFO with WIDTH = DATA_W+1, result FIFO with WIDTH = DATA_W.

Test Plan:
- Reset, then write 3 words (0xA, 0xB, 0xC with last) while the chip acks with done one cycle after each intrpt -> dataBus sequence 0xA, 0xB, 0xC with cmd = 1, then intrpt = 1 with cmd = 0.
- Process acked, chip pulses done 4 times with 0x11..0x14, rd_ready = 1 -> rd_data 0x11, 0x12, 0x13, 0x14 in order, busy = 0 afterwards, res_ovf = 0.
- Write 16 words with DEPTH = 16 and hold done = 0 -> wr_ready = 0 after the 16th write; a 17th write is ignored; the first ack pops and wr_ready returns to 1.
- Write 2 non-last words, ack both, delay the third -> GAP holds intrpt = 0; the third word (last) written later -> LOAD, then PROCESS.
- RES_DEPTH = 2, rd_ready = 0, 4 result pulses -> 2 words stored, res_ovf = 1, state returns to IDLE.
- Assert reset during COLLECT -> intrpt = 0, cmd = 1, rd_valid = 0, wr_ready = 1 asynchronously.
